psum_acc_mem: RTL

Parametrised partial-sum memory with in-place read-modify-write accumulation, replacing the plain write-only psum storage in the core. Accepts one column-vector of psums per cycle from the OFIFO side, either overwrites or adds it lane-wise into a DEPTH-entry store, forwards across adjacent same-address operations, and serves a separate readout port with optional ReLU. Includes a hardware clear sweep, so multi-tile accumulation needs no host read-back.

---
 rtl/psum_acc_mem.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/psum_acc_mem.sv
// psum_acc_mem
//   Partial-sum store with in-place read-modify-write accumulation.
//   Each accepted request either overwrites an entry or adds its lanes
//   into it, with per-lane saturation. A separate readout path can clamp
//   negative lanes to zero (ReLU). A clear sweep zeroes every entry.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   write/accumulate handshake
//   in_acc           0 = overwrite, 1 = accumulate (saturating)
//   in_addr/in_data  target entry and col lanes of signed psum_bw data
//   rd_en/rd_addr    readout request; data appears two cycles later
//   relu_en          clamp negative lanes on readout, sampled with rd_en
//   rd_valid/rd_data readout response
//   clr_start        start the clear sweep (honoured only when idle)
//   busy             drain or clear sweep in progress
//   sat_sticky       an accumulate lane saturated since the last clear/reset
//   op_count         accepted write/accumulate operations, wraps at 2^16
module psum_acc_mem #(
   parameter int col       = 8,
   parameter int psum_bw   = 16,
   parameter int DEPTH     = 2048,
   parameter int ADD_WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_acc,
   input  logic [ADD_WIDTH-1:0]     in_addr,
   input  logic [col*psum_bw-1:0]   in_data,
   input  logic                     rd_en,
   input  logic [ADD_WIDTH-1:0]     rd_addr,
   input  logic                     relu_en,
   output logic                     rd_valid,
   output logic [col*psum_bw-1:0]   rd_data,
   input  logic                     clr_start,
   output logic                     busy,
   output logic                     sat_sticky,
   output logic [15:0]              op_count
);

   localparam int W = col * psum_bw;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] CLEAR = 2'd2;

   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

   localparam logic signed [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic signed [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

   // One guard bit is enough to hold any sum of two lanes.
   function automatic logic signed [psum_bw:0] wide_add(
      input logic signed [psum_bw-1:0] a,
      input logic signed [psum_bw-1:0] b
   );
      return {a[psum_bw-1], a} + {b[psum_bw-1], b};
   endfunction

   function automatic logic lane_ovf(input logic signed [psum_bw:0] s);
      return s[psum_bw] ^ s[psum_bw-1];
   endfunction

   function automatic logic signed [psum_bw-1:0] sat_lane(input logic signed [psum_bw:0] s);
      if (lane_ovf(s)) begin
         return s[psum_bw] ? LANE_MIN : LANE_MAX;
      end
      return s[psum_bw-1:0];
   endfunction

   function automatic logic signed [psum_bw-1:0] relu_lane(input logic signed [psum_bw-1:0] v);
      return v[psum_bw-1] ? '0 : v;
   endfunction

   logic [1:0]            state;
   logic [ADD_WIDTH-1:0]  clr_ctr;
   logic                  accept;
   logic                  rd_go;
   logic [ADD_WIDTH-1:0]  raddr;

   logic [W-1:0]          mem [DEPTH];
   logic [W-1:0]          mem_q;

   logic                  vld_p1;
   logic                  acc_p1;
   logic [ADD_WIDTH-1:0]  addr_p1;
   logic [W-1:0]          data_p1;

   logic                  vld_p2;
   logic [ADD_WIDTH-1:0]  addr_p2;
   logic [W-1:0]          wdata_p2;

   logic                  rd_vld_p1;
   logic [ADD_WIDTH-1:0]  rd_addr_p1;
   logic                  relu_p1;

   logic                  fwd_hit;
   logic [W-1:0]          operand;
   logic [W-1:0]          result;
   logic                  any_sat;
   logic signed [psum_bw:0] sum;

   logic [W-1:0]          rd_vec;
   logic [W-1:0]          rd_next;

   logic                  wen;
   logic [ADD_WIDTH-1:0]  waddr;
   logic [W-1:0]          wdata;

   assign busy     = (state != IDLE);
   // Readout and clear requests take the single read port / block the pipe.
   assign in_ready = reset && (state == IDLE) && !rd_en && !clr_start;
   assign accept   = in_valid && in_ready;
   assign rd_go    = rd_en && (state == IDLE);
   assign raddr    = rd_go ? rd_addr : in_addr;

   // ---- S0: array read issue, request captured ----
   always_ff @(posedge clk) begin
      if (rd_go || accept) begin
         mem_q <= mem[raddr];
      end
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         acc_p1  <= in_acc;
         addr_p1 <= in_addr;
         data_p1 <= in_data;
      end
      if (rd_go) begin
         rd_addr_p1 <= rd_addr;
         relu_p1    <= relu_en;
      end
      addr_p2  <= addr_p1;
      wdata_p2 <= result;
   end

   // ---- S1: operand select, lane arithmetic, write ----
   // The array read sampled at the same edge the previous op wrote, so
   // that op's result is taken from the p2 copy instead of the stale read.
   always_comb begin
      fwd_hit = vld_p2 && (addr_p2 == addr_p1);
      operand = fwd_hit ? wdata_p2 : mem_q;
      result  = '0;
      any_sat = 1'b0;
      sum     = '0;
      for (int i = 0; i < col; i++) begin
         sum = wide_add(operand[i*psum_bw +: psum_bw], data_p1[i*psum_bw +: psum_bw]);
         if (acc_p1) begin
            result[i*psum_bw +: psum_bw] = sat_lane(sum);
            any_sat = any_sat | lane_ovf(sum);
         end else begin
            result[i*psum_bw +: psum_bw] = data_p1[i*psum_bw +: psum_bw];
         end
      end
   end

   // The pipe is always drained before CLEAR, so the two writers never meet.
   always_comb begin
      wen   = vld_p1 || (state == CLEAR);
      waddr = vld_p1 ? addr_p1 : clr_ctr;
      wdata = vld_p1 ? result : '0;
   end

   // ---- Readout stage 1: forward, ReLU, output register ----
   always_comb begin
      rd_vec  = (vld_p2 && (addr_p2 == rd_addr_p1)) ? wdata_p2 : mem_q;
      rd_next = '0;
      for (int i = 0; i < col; i++) begin
         rd_next[i*psum_bw +: psum_bw] = relu_p1 ? relu_lane(rd_vec[i*psum_bw +: psum_bw])
                                                 : rd_vec[i*psum_bw +: psum_bw];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         clr_ctr    <= '0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         rd_vld_p1  <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         sat_sticky <= 1'b0;
         op_count   <= '0;
      end else begin
         vld_p1    <= accept;
         vld_p2    <= vld_p1;
         rd_vld_p1 <= rd_go;
         rd_valid  <= rd_vld_p1;
         if (rd_vld_p1) begin
            rd_data <= rd_next;
         end
         if (accept) begin
            op_count <= op_count + 16'd1;
         end
         if ((state == IDLE) && clr_start) begin
            sat_sticky <= 1'b0;
         end else if (vld_p1 && acc_p1 && any_sat) begin
            sat_sticky <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state   <= CLEAR;
               clr_ctr <= '0;
            end
            CLEAR: begin
               clr_ctr <= clr_ctr + ADD_WIDTH'(1);
               if (clr_ctr == LAST_ADDR) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
